mem_arbiter: RTL

Shares the single external memory port of the omega8 core between three requesters: instruction fetch (port 0), CPU data load/store (port 1), and an external DMA master (port 2). It arbitrates round-robin and runs one memory transaction at a time with a req/ready handshake and timeout. While DMA owns the port, it asserts a hold to the CPU. It sits between the CPU's fetch/memread paths and the memory interface.

---
 rtl/omega8_pkg.sv | 19 +
 rtl/mem_rr_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/omega8_pkg.sv
// rtl/omega8_pkg.sv - shared types and constants for the omega8 memory arbiter
//
// Holds the arbiter state encoding, the requester port numbering and the
// port count used by mem_arbiter and mem_rr_pick.
package omega8_pkg;

  localparam int NPORT     = 3;

  localparam int PORT_IF   = 0;  // instruction fetch
  localparam int PORT_DATA = 1;  // CPU load/store
  localparam int PORT_DMA  = 2;  // external DMA master

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational round-robin picker for three requesters
//
// Searches last+1, last+2, last+3 (mod 3) and returns the first requesting
// port as both a one-hot grant and an index. With no request the grant is 0.
//
// Ports:
//   req   in   NPORT  request vector, bit n = port n
//   last  in   2      index of the most recently served port
//   gnt   out  NPORT  one-hot winner (0 if no request)
//   idx   out  2      index of the winner (0 if no request)
module mem_rr_pick
  import omega8_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       last,
  output logic [NPORT-1:0] gnt,
  output logic [1:0]       idx
);

  int p;

  // Walk the search order backwards so the closest port after `last`
  // is the one that overwrites the result last.
  always_comb begin
    gnt = '0;
    idx = 2'd0;
    p   = 0;
    for (int k = NPORT; k >= 1; k--) begin
      p = (int'(last) + k) % NPORT;
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = 2'(p);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch, data and DMA
//
// One transaction at a time: IDLE picks a requester and latches its command,
// BUSY drives the memory port until ready or timeout, DONE shows the one-cycle
// done/err pulse and releases the grant.
//
// Ports:
//   clk          in   1      clock, rising edge
//   i_rst        in   1      asynchronous active-high reset
//   i_req        in   3      per-port request
//   i_we         in   3      per-port write enable
//   i_addr       in   3*AW   per-port address, port n at [n*AW +: AW]
//   i_wdata      in   3*DW   per-port write data, port n at [n*DW +: DW]
//   o_gnt        out  3      one-hot owner of the memory port
//   o_done       out  3      completion pulse to the owner
//   o_err        out  3      timeout pulse to the owner
//   o_rdata      out  DW     read data, valid with o_done
//   o_hold       out  1      CPU hold, high while DMA owns the port
//   o_mem_req    out  1      memory request
//   o_mem_we     out  1      memory write enable
//   o_mem_addr   out  AW     memory address
//   o_mem_wdata  out  DW     memory write data
//   i_mem_ready  in   1      memory completes the current request
//   i_mem_rdata  in   DW     memory read data, valid with i_mem_ready
module mem_arbiter
  import omega8_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NPORT-1:0]   i_req,
  input  logic [NPORT-1:0]   i_we,
  input  logic [NPORT*AW-1:0] i_addr,
  input  logic [NPORT*DW-1:0] i_wdata,
  output logic [NPORT-1:0]   o_gnt,
  output logic [NPORT-1:0]   o_done,
  output logic [NPORT-1:0]   o_err,
  output logic [DW-1:0]      o_rdata,
  output logic               o_hold,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic               i_mem_ready,
  input  logic [DW-1:0]      i_mem_rdata
);

  // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_t state, next_state;

  logic [NPORT-1:0] pick_gnt;
  logic [1:0]       pick_idx;
  logic [1:0]       last;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [CW-1:0]    cnt;

  logic load, finish_ok, finish_to, cnt_inc;

  mem_rr_pick u_pick (
    .req  (i_req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        // Ready is checked first so it wins over a simultaneous timeout.
        if (i_mem_ready) begin
          finish_ok  = 1'b1;
          next_state = DONE;
        end else if (TIMEOUT != 0 && cnt == CNT_LIMIT) begin
          finish_to  = 1'b1;
          next_state = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      last    <= 2'(PORT_DMA);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      o_gnt   <= '0;
      o_done  <= '0;
      o_err   <= '0;
      o_rdata <= '0;
      o_hold  <= 1'b0;
    end else begin
      o_done <= '0;
      o_err  <= '0;
      if (load) begin
        last    <= pick_idx;
        we_q    <= i_we[pick_idx];
        addr_q  <= i_addr[pick_idx*AW +: AW];
        wdata_q <= i_wdata[pick_idx*DW +: DW];
        cnt     <= '0;
        o_gnt   <= pick_gnt;
        o_hold  <= pick_gnt[PORT_DMA];
      end
      if (finish_ok) begin
        if (!we_q) o_rdata <= i_mem_rdata;
        o_done <= o_gnt;
      end
      if (finish_to) o_err <= o_gnt;
      if (cnt_inc && cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
      if (state == DONE) begin
        o_gnt  <= '0;
        o_hold <= 1'b0;
        cnt    <= '0;
      end
    end
  end

  // Memory command is only presented while BUSY; all zeros otherwise.
  assign o_mem_req   = (state == BUSY);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? addr_q  : '0;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;

endmodule
